// File: rtl/fetch_queue.sv
// Instruction fetch queue: splits 64-bit icache blocks into 32-bit entries held
// in a circular buffer and presents up to two entries per cycle to decode.
module fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] NOP_INST = 32'h03400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [63:0] in_data,
  input  logic [6:0]  in_exception,
  input  logic [31:0] in_badv,
  output logic        in_ready,
  output logic        out_valid0,
  output logic        out_valid1,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic [6:0]  out_exception0,
  output logic [6:0]  out_exception1,
  output logic [31:0] out_badv0,
  output logic [31:0] out_badv1,
  input  logic [1:0]  deq_num
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [6:0]  exc_mem  [DEPTH];
  logic [31:0] badv_mem [DEPTH];

  logic [AW-1:0] head, tail;
  logic [AW-1:0] head_nxt1, tail_nxt1;
  logic [AW:0]   count;

  logic        push_fire, push_two;
  logic [1:0]  push_n, pop_n, deq_eff, avail;
  logic [31:0] first_inst;
  logic [6:0]  first_exc;
  logic [31:0] first_badv;

  assign head_nxt1 = head + 1'b1;
  assign tail_nxt1 = tail + 1'b1;

  // Readiness depends only on the current occupancy so a 2-entry push always fits.
  assign in_ready = (count <= (AW+1)'(DEPTH - 2));

  assign push_fire = in_valid & in_ready & ~flush;
  assign push_two  = (in_exception == 7'd0) & ~in_pc[2];
  assign push_n    = push_fire ? (push_two ? 2'd2 : 2'd1) : 2'd0;

  always_comb begin
    first_inst = in_pc[2] ? in_data[63:32] : in_data[31:0];
    first_exc  = 7'd0;
    first_badv = 32'd0;
    if (in_exception != 7'd0) begin
      first_inst = NOP_INST;
      first_exc  = in_exception;
      first_badv = in_badv;
    end
  end

  // An exception entry at the head is always issued alone so decode sees it precisely.
  always_comb begin
    out_valid0 = (count != '0);
    out_valid1 = (count >= (AW+1)'(2)) && (exc_mem[head] == 7'd0);

    out_pc0        = 32'd0;
    out_inst0      = 32'd0;
    out_exception0 = 7'd0;
    out_badv0      = 32'd0;
    out_pc1        = 32'd0;
    out_inst1      = 32'd0;
    out_exception1 = 7'd0;
    out_badv1      = 32'd0;

    if (out_valid0) begin
      out_pc0        = pc_mem[head];
      out_inst0      = inst_mem[head];
      out_exception0 = exc_mem[head];
      out_badv0      = badv_mem[head];
    end
    if (out_valid1) begin
      out_pc1        = pc_mem[head_nxt1];
      out_inst1      = inst_mem[head_nxt1];
      out_exception1 = exc_mem[head_nxt1];
      out_badv1      = badv_mem[head_nxt1];
    end
  end

  always_comb begin
    deq_eff = (deq_num == 2'd3) ? 2'd2 : deq_num;
    avail   = {1'b0, out_valid0} + {1'b0, out_valid1};
    pop_n   = (deq_eff < avail) ? deq_eff : avail;
    if (flush) pop_n = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
    end
  end

  // Storage needs no reset: every read is gated by the valid flags.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      pc_mem[tail]   <= in_pc;
      inst_mem[tail] <= first_inst;
      exc_mem[tail]  <= first_exc;
      badv_mem[tail] <= first_badv;
      if (push_two) begin
        pc_mem[tail_nxt1]   <= in_pc + 32'd4;
        inst_mem[tail_nxt1] <= in_data[63:32];
        exc_mem[tail_nxt1]  <= 7'd0;
        badv_mem[tail_nxt1] <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: a queue-based reference model tracks
// expected entries and a negedge monitor compares every DUT output against it.
module tb_fetch_queue;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h03400000;
  localparam logic [6:0]  ADEF  = 7'h08;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  exc;
    logic [31:0] badv;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [31:0] in_pc, in_badv;
  logic [63:0] in_data;
  logic [6:0]  in_exception;
  logic [1:0]  deq_num;
  logic        in_ready, out_valid0, out_valid1;
  logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1, out_badv0, out_badv1;
  logic [6:0]  out_exception0, out_exception1;

  entry_t refQ[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_data(in_data), .in_exception(in_exception), .in_badv(in_badv),
    .in_ready(in_ready), .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_exception0(out_exception0), .out_exception1(out_exception1),
    .out_badv0(out_badv0), .out_badv1(out_badv1), .deq_num(deq_num)
  );

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: one step applies the rules to the inputs live at the clock edge.
  task automatic stepModel();
    entry_t pushList[$];
    int sz, avail, want, npop;
    if (rst || flush) begin
      refQ.delete();
      return;
    end
    sz    = refQ.size();
    avail = (sz >= 1) + ((sz >= 2 && refQ[0].exc == 0) ? 1 : 0);
    want  = (deq_num == 2'd3) ? 2 : int'(deq_num);
    npop  = (want < avail) ? want : avail;
    if (in_valid && sz <= DEPTH - 2) begin
      if (in_exception != 0)
        pushList.push_back('{in_pc, NOP, in_exception, in_badv});
      else if (in_pc[2] == 1'b0) begin
        pushList.push_back('{in_pc, in_data[31:0], 7'd0, 32'd0});
        pushList.push_back('{in_pc + 32'd4, in_data[63:32], 7'd0, 32'd0});
      end else
        pushList.push_back('{in_pc, in_data[63:32], 7'd0, 32'd0});
    end
    repeat (npop) void'(refQ.pop_front());
    foreach (pushList[i]) refQ.push_back(pushList[i]);
  endtask

  task automatic checkOutput();
    entry_t e0, e1;
    bit v0, v1;
    e0 = '{32'd0, 32'd0, 7'd0, 32'd0};
    e1 = e0;
    v0 = refQ.size() >= 1;
    v1 = refQ.size() >= 2 && refQ[0].exc == 0;
    if (v0) e0 = refQ[0];
    if (v1) e1 = refQ[1];
    compare("in_ready", 32'(in_ready), 32'(refQ.size() <= DEPTH - 2));
    compare("out_valid0", 32'(out_valid0), 32'(v0));
    compare("out_valid1", 32'(out_valid1), 32'(v1));
    compare("out_pc0", out_pc0, e0.pc);
    compare("out_inst0", out_inst0, e0.inst);
    compare("out_exception0", 32'(out_exception0), 32'(e0.exc));
    compare("out_badv0", out_badv0, e0.badv);
    compare("out_pc1", out_pc1, e1.pc);
    compare("out_inst1", out_inst1, e1.inst);
    compare("out_exception1", 32'(out_exception1), 32'(e1.exc));
    compare("out_badv1", out_badv1, e1.badv);
  endtask

  // Each call closes the previous cycle in the model, then drives the next cycle's inputs.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [63:0] data,
                               input logic [6:0] exc, input logic [31:0] badv,
                               input logic fl, input logic [1:0] dq, output bit accepted);
    @(posedge clk);
    stepModel();
    #1;
    in_valid     = v;
    in_pc        = pc;
    in_data      = data;
    in_exception = exc;
    in_badv      = badv;
    flush        = fl;
    deq_num      = dq;
    accepted     = v && !fl && (refQ.size() <= DEPTH - 2);
  endtask

  task automatic idle(input logic [1:0] dq);
    bit a;
    applyStimulus(1'b0, 32'd0, 64'd0, 7'd0, 32'd0, 1'b0, dq, a);
  endtask

  task automatic pushBlock(input logic [31:0] pc, input logic [63:0] data, input logic [1:0] dq);
    bit a;
    applyStimulus(1'b1, pc, data, 7'd0, 32'd0, 1'b0, dq, a);
  endtask

  initial begin
    @(negedge clk);
    while (!done) begin
      checkOutput();
      @(negedge clk);
    end
  end

  initial begin
    bit acc;
    int got;
    logic [31:0] pc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0;
    in_exception = '0; in_badv = '0; deq_num = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Aligned block, then drain both entries.
    pushBlock(32'h1c000000, 64'h00000002_00000001, 2'd0);
    idle(2'd0);
    idle(2'd2);
    idle(2'd0);

    // Odd pc gives a single upper-half entry.
    pushBlock(32'h1c000004, 64'hAAAA0000_BBBB0000, 2'd0);
    idle(2'd0);
    idle(2'd1);

    // Exception entry issues alone between two pairs.
    pushBlock(32'h1c000000, 64'h11111111_00000000, 2'd0);
    applyStimulus(1'b1, 32'h1c000010, 64'hdeadbeef_deadbeef, ADEF, 32'h1c000010, 1'b0, 2'd0, acc);
    pushBlock(32'h1c000018, 64'h33333333_22222222, 2'd0);
    idle(2'd2);
    idle(2'd2);
    idle(2'd2);
    idle(2'd2);

    // Fill to 7, offer a dropped block, then deq 2 with in_valid high.
    pushBlock(32'h1c000100, 64'h1, 2'd0);
    pushBlock(32'h1c000108, 64'h2, 2'd0);
    pushBlock(32'h1c000110, 64'h3, 2'd0);
    pushBlock(32'h1c00011c, 64'h4_00000000, 2'd0);
    pushBlock(32'h1c000120, 64'h5, 2'd0);
    pushBlock(32'h1c000120, 64'h5, 2'd2);
    pushBlock(32'h1c000120, 64'h5, 2'd0);
    idle(2'd0);

    // Flush with push and pop requested at count 6.
    idle(2'd3); idle(2'd3); idle(2'd3); idle(2'd3); idle(2'd0);
    pushBlock(32'h1c000200, 64'h1, 2'd0);
    pushBlock(32'h1c000208, 64'h2, 2'd0);
    pushBlock(32'h1c000210, 64'h3, 2'd0);
    applyStimulus(1'b1, 32'h1c000218, 64'h4, 7'd0, 32'd0, 1'b1, 2'd2, acc);
    idle(2'd0);
    idle(2'd0);

    // Stream 20 aligned blocks across pointer wrap, holding each until accepted.
    pc = 32'h1c001000;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      applyStimulus(1'b1, pc, {pc + 32'h100 + 32'd4, pc + 32'h100}, 7'd0, 32'd0, 1'b0,
                    (cyc % 2 == 0) ? 2'd1 : 2'd2, acc);
      if (acc) begin
        got++;
        pc = pc + 32'd8;
      end
    end
    checks++;
    if (got < 20) begin
      errors++;
      $display("[TB] FAIL wrap_stream: got %0d accepted blocks expected 20", got);
    end
    for (int i = 0; i < 12; i++) idle(2'd2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [6:0] e;
      logic [31:0] rpc;
      rpc = 32'h1c000000 | ($urandom & 32'h0000fffc);
      e = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      applyStimulus($urandom_range(0, 9) < 7, rpc, {$urandom, $urandom}, e, $urandom,
                    $urandom_range(0, 39) == 0,
                    (i % 100 < 50) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3)), acc);
    end

    // Asynchronous reset mid-stream clears outputs before any edge.
    pushBlock(32'h1c003000, 64'h7, 2'd0);
    @(posedge clk);
    stepModel();
    #1 in_valid = 1'b0; deq_num = 2'd0;
    #2 rst = 1'b1;
    refQ.delete();
    #1 checkOutput();
    @(posedge clk);
    stepModel();
    #1 rst = 1'b0;
    pushBlock(32'h1c004000, 64'h9_00000008, 2'd0);
    idle(2'd1);
    idle(2'd0);
    @(posedge clk);
    stepModel();
    #1 done = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the instruction cache and decode. Each accepted 64-bit fetch block from the icache read port is split into one or two 32-bit instruction entries, buffered in a circular queue, and presented to decode up to two entries per cycle. Fetch exceptions travel in order as single entries carrying a NOP so decode raises them precisely.

## Interface
- DEPTH, 8, queue entries; power of two, >= 4
- NOP_INST, 32'h03400000, instruction word stored in exception entries
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- flush  in  1  discard all entries and ignore this cycle's push
- in_valid  in  1  fetch block offered (icache data_valid)
- in_pc  in  32  pc of the fetched address; in_pc[1:0] is always 0
- in_data  in  64  fetch block; [31:0] at pc with bit2=0, [63:32] at pc with bit2=1
- in_exception  in  7  fetch exception code, 0 = none
- in_badv  in  32  bad virtual address for in_exception
- in_ready  out  1  queue can accept a block this cycle
- out_valid0 / out_valid1  out  1 each  slot 0 / slot 1 entry valid
- out_pc0 / out_pc1  out  32 each  entry pc
- out_inst0 / out_inst1  out  32 each  instruction word
- out_exception0 / out_exception1  out  7 each  entry exception code
- out_badv0 / out_badv1  out  32 each  entry badv
- deq_num  in  2  entries decode consumes this cycle: 0, 1 or 2

## Operation
- Storage: DEPTH entries {pc, inst, exception, badv}; head and tail pointers of log2(DEPTH) bits wrapping modulo DEPTH; count of log2(DEPTH)+1 bits, range 0..DEPTH.
- in_ready = (count <= DEPTH-2), computed from the current count only, never from same-cycle deq_num.
- Push when in_valid & in_ready & !flush:
  - in_exception != 0: one entry {in_pc, NOP_INST, in_exception, in_badv}.
  - else in_pc[2]=0: two entries {in_pc, in_data[31:0], 0, 0} then {in_pc+4, in_data[63:32], 0, 0}.
  - else: one entry {in_pc, in_data[63:32], 0, 0}.
- in_valid while in_ready=0 is dropped; the icache holds its request until in_ready is high.
- Pop: slot 0 = head entry, slot 1 = head+1 (mod DEPTH).
  - out_valid0 = (count >= 1).
  - out_valid1 = (count >= 2) & (out_exception0 == 0); an exception entry always issues alone in slot 0.
  - Effective pop = min(deq_num, out_valid0 + out_valid1); deq_num=3 is treated as 2. Slot 1 is never popped without slot 0.
- count_next = count + push_n - pop_n; push and pop in the same cycle are both honoured.
- Output data fields are driven to 0 when the corresponding out_valid is 0.
- flush: head, tail and count go to 0 at the next edge; the same-cycle push and pop are ignored.

## Timing
- Reset (async, active-high): head=tail=count=0; out_valid0=out_valid1=0; all out_* data = 0; in_ready=1.
- Latency: an entry pushed at edge N is visible on out_* after edge N; there is no input-to-output bypass.
- Pop at edge N advances head, and the new head is visible after edge N.
- Full: count = DEPTH-1 or DEPTH gives in_ready=0, even if deq_num=2 that cycle.
- Empty: count=0 gives both valids 0; deq_num is ignored.
- Wrap-around: the two entries of a 2-entry push may straddle index DEPTH-1 -> 0, and slot 1 may read index 0 while head = DEPTH-1.
- flush together with rst: rst wins. flush with in_valid: nothing is stored.

## Test plan
- Aligned block: push pc=0x1c000000, data=0x00000002_00000001, deq_num=0 -> next cycle out0={0x1c000000,0x00000001}, out1={0x1c000004,0x00000002}, both valid; deq_num=2 -> queue empty the cycle after.
- Odd pc: push pc=0x1c000004, data=0xAAAA0000_BBBB0000 -> single entry {0x1c000004, 0xAAAA0000}, out_valid1=0.
- Exception: push aligned block, then pc=0x1c000010 with exception=ADEF, badv=0x1c000010, then another aligned block -> head pair issues, then the exception entry alone (inst=0x03400000, out_valid1=0 despite count=3), then the remaining pair.
- Full/backpressure: fill to count 7 with deq_num=0 -> in_ready=0 and an offered block is not stored; deq_num=2 with in_valid high -> no push that cycle, in_ready=1 next cycle, then count 5 -> 7 on the following push.
- Wrap: stream 20 aligned blocks with alternating deq_num 1/2 -> pc order strictly +4 with no loss or duplication across pointer wrap.
- Flush/reset: count=6, assert flush with in_valid=1 and deq_num=2 -> next cycle count=0, valids 0, in_ready=1. Assert rst mid-stream -> outputs 0 immediately, without waiting for a clock edge.
